cordic_launch_stage: RTL and testbench
======================================

Name: cordic_launch_stage

Overview:
- Front end of the CORDIC pipeline. Sits directly upstream of the first cordic_info_stage.
- Accepts target angles from the host over a valid/ready handshake and buffers them in a 2-entry skid FIFO.
- Each cycle the pipeline advances (clk_en=1), it launches one rotation seed: angle=0, x=K, y=0, plus the target and a valid flag.
- Isolates the host from pipeline stalls; optionally clamps out-of-range targets.

Parameters:
- INTEGER_WIDTH, 2, integer bits of the signed fixed-point format
- DECIMAL_WIDTH, 20, fractional bits
- DATA_WIDTH, INTEGER_WIDTH+DECIMAL_WIDTH, word width (22)
- K_INIT, 22'd636751, CORDIC gain seed 0.6072529 in Q2.20
- MAX_ANGLE, 22'd1647099, pi/2 in Q2.20; the clamp limit

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- clk_en  in  1  pipeline advance enable, shared with downstream stages
- flush  in  1  synchronous clear of buffer and output valid
- in_valid  in  1  host offers in_target
- in_target  in  DATA_WIDTH  signed Q2.20 target angle
- in_ready  out  1  buffer can accept
- valid_out  out  1  launched seed is valid
- target_out  out  DATA_WIDTH  target for the first stage
- angle  out  DATA_WIDTH  seed angle, always 0
- x  out  DATA_WIDTH  seed x = K_INIT
- y  out  DATA_WIDTH  seed y = 0
- sat_flag  out  1  launched target was clamped
- occupancy  out  2  entries held in the skid buffer (0..2)

Behaviour:
- Reset (async, active-high): buffer empty, occupancy=0, valid_out=0, target_out=0, angle=0, x=0, y=0, sat_flag=0.
- After reset, x shows 0 until the first launch.
- in_ready = (occupancy != 2). It is driven combinationally from the registered count only, with no path from clk_en or in_valid.
- Enqueue: in_valid && in_ready at a rising edge writes in_target to the tail.
- Launch: clk_en && occupancy>0 at a rising edge loads the head into the output registers and pops it:
  - valid_out=1, angle=0, x=K_INIT, y=0
  - target_out=head
  - sat_flag=head's clamp bit
- Bubble: clk_en && occupancy==0 sets valid_out=0. Data outputs hold their previous values.
- Stall: clk_en=0 holds all outputs unchanged. Enqueue continues until the buffer is full.
- Simultaneous enqueue and launch: occupancy is unchanged and FIFO order is preserved.
- On an empty buffer, an enqueue and a launch at the same edge do NOT bypass. The launch sees empty, and the new target launches at the next enabled edge.
- Latency: an entry accepted at edge N launches at the first edge ≥N+1 with clk_en=1. Minimum latency is 1 cycle.
- Throughput: one target per cycle when clk_en is held high.
- Full: in_valid while occupancy==2 is not accepted. The host must hold in_target until in_ready.
- flush: has priority over enqueue and launch. At the edge it empties the buffer and sets valid_out=0 and sat_flag=0, regardless of clk_en. Data outputs hold.
- Reset mid-operation discards all buffered entries immediately.
- Buffer: 2 entries of DATA_WIDTH+1 bits (target plus clamp bit), with 1-bit head/tail pointers that wrap.

Optional Feature:
- Macro: CORDIC_LAUNCH_CLAMP_EN.
- When defined: at enqueue, signed targets > MAX_ANGLE are stored as MAX_ANGLE and targets < −MAX_ANGLE are stored as −MAX_ANGLE. Each such entry's clamp bit is set, and sat_flag=1 on the cycle that entry launches.
- When undefined: targets are stored unmodified, no comparators are built, and sat_flag is tied 0.

Decomposition:
- Shared package cordic_pkg holds:
  - INTEGER_WIDTH, DECIMAL_WIDTH, DATA_WIDTH
  - K_INIT, MAX_ANGLE
  - the fixed-point word typedef, reused by cordic_info_stage instances
- One sub-module, cordic_skid_fifo: 2-entry, parameterised width, with push/pop/flush/count.
- Seed generation and clamping remain in cordic_launch_stage.

Test Plan:
- Reset then idle: assert reset mid-run with 2 entries buffered → occupancy=0, valid_out=0, in_ready=1 immediately, without waiting for a clock.
- Streaming: clk_en=1, push 0x040000, 0x080000, 0x0C0000 back-to-back → launched in order on consecutive cycles, x=636751, y=0, angle=0, one cycle after each accept.
- Stall/full: clk_en=0, push 0x010000 and 0x020000, then a third push → occupancy=2, in_ready=0, third value not accepted. Raise clk_en → 0x010000 launches, then 0x020000, then the third value after re-offer.
- Bubble: one push, clk_en high for 3 cycles → valid_out pattern 1,0,0 with target_out held at the pushed value.
- Flush with simultaneous push: occupancy=1, flush=1, in_valid=1 → occupancy=0, valid_out=0, pushed value dropped.
- Clamp (CORDIC_LAUNCH_CLAMP_EN): push 22'd1900000 and −1900000 → target_out=1647099 then −1647099 with sat_flag=1. Push 1000 → sat_flag=0. With the macro undefined, 1900000 passes through with sat_flag=0.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared CORDIC fixed-point definitions (Q2.20 word, gain seed, clamp limit).
package cordic_pkg;
  localparam int INTEGER_WIDTH = 2;
  localparam int DECIMAL_WIDTH = 20;
  localparam int DATA_WIDTH    = INTEGER_WIDTH + DECIMAL_WIDTH;

  typedef logic signed [DATA_WIDTH-1:0] fixed_t;

  localparam fixed_t K_INIT    = 22'd636751;   // 0.6072529
  localparam fixed_t MAX_ANGLE = 22'd1647099;  // pi/2
endpackage

// File: rtl/cordic_launch_stage_if.sv
// Host-side target handshake for the CORDIC launch stage.
interface cordic_launch_stage_if;
  import cordic_pkg::*;
  logic   in_valid;
  fixed_t in_target;
  logic   in_ready;

  modport master (output in_valid, output in_target, input  in_ready);
  modport slave  (input  in_valid, input  in_target, output in_ready);
endinterface

// File: rtl/cordic_skid_fifo.sv
// Two-entry skid FIFO with 1-bit wrapping pointers; flush beats push/pop.
module cordic_skid_fifo #(
  parameter int W = 23
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);
  logic [W-1:0] mem_q [2];
  logic         head_q, tail_q;
  logic [1:0]   count_q, count_d;
  logic         push_ok, pop_ok;

  assign push_ok = push && (count_q != 2'd2);
  assign pop_ok  = pop  && (count_q != 2'd0);
  assign dout    = mem_q[head_q];
  assign count   = count_q;

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      count_q <= 2'd0;
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
    end else if (flush) begin
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (push_ok) begin
        mem_q[tail_q] <= din;
        tail_q        <= ~tail_q;
      end
      if (pop_ok) head_q <= ~head_q;
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/cordic_launch_stage.sv
// CORDIC pipeline front end: buffers host targets and launches rotation seeds.
// Optional target clamping to +/-pi/2 is enabled by CORDIC_LAUNCH_CLAMP_EN.
module cordic_launch_stage
  import cordic_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_en,
  input  logic                  flush,
  cordic_launch_stage_if.slave  host,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] target_out,
  output logic [DATA_WIDTH-1:0] angle,
  output logic [DATA_WIDTH-1:0] x,
  output logic [DATA_WIDTH-1:0] y,
  output logic                  sat_flag,
  output logic [1:0]            occupancy
);
  localparam int EW = DATA_WIDTH + 1;

  logic [EW-1:0]   enq_entry, head_entry;
  logic [1:0]      occ;
  logic            push, launch;
  fixed_t          enq_target;
  logic            enq_clamp;

  logic            valid_q;
  fixed_t          target_q, angle_q, x_q, y_q;

  // Ready depends only on the registered count so the host never sees clk_en.
  assign host.in_ready = (occ != 2'd2);
  assign push          = host.in_valid && host.in_ready;
  assign launch        = clk_en && (occ != 2'd0);

`ifdef CORDIC_LAUNCH_CLAMP_EN
  logic sat_q;
  always_comb begin
    enq_target = host.in_target;
    enq_clamp  = 1'b0;
    if (host.in_target > MAX_ANGLE) begin
      enq_target = MAX_ANGLE;
      enq_clamp  = 1'b1;
    end else if (host.in_target < -MAX_ANGLE) begin
      enq_target = -MAX_ANGLE;
      enq_clamp  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       sat_q <= 1'b0;
    else if (flush)  sat_q <= 1'b0;
    else if (launch) sat_q <= head_entry[DATA_WIDTH];
  end
  assign sat_flag = sat_q;
`else
  logic unused_clamp;
  assign enq_target   = host.in_target;
  assign enq_clamp    = 1'b0;
  assign sat_flag     = 1'b0;
  assign unused_clamp = head_entry[DATA_WIDTH];
`endif

  assign enq_entry = {enq_clamp, enq_target};

  cordic_skid_fifo #(.W(EW)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (push),
    .pop   (clk_en),
    .din   (enq_entry),
    .dout  (head_entry),
    .count (occ)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q  <= 1'b0;
      target_q <= '0;
      angle_q  <= '0;
      x_q      <= '0;
      y_q      <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (clk_en) begin
      valid_q <= launch;
      if (launch) begin
        target_q <= fixed_t'(head_entry[DATA_WIDTH-1:0]);
        angle_q  <= '0;
        x_q      <= K_INIT;
        y_q      <= '0;
      end
    end
  end

  assign valid_out  = valid_q;
  assign target_out = target_q;
  assign angle      = angle_q;
  assign x          = x_q;
  assign y          = y_q;
  assign occupancy  = occ;
endmodule

// File: tb/tb_cordic_launch_stage.sv
// Directed bench for cordic_launch_stage: streaming, stall/full, bubble, flush, clamp, reset.
module tb_cordic_launch_stage;
  import cordic_pkg::*;

  logic clk = 1'b0;
  logic reset, clk_en, flush;
  logic valid_out, sat_flag;
  logic [DATA_WIDTH-1:0] target_out, angle, x, y;
  logic [1:0] occupancy;
  int checks = 0;
  int errors = 0;

  localparam logic [21:0] BIG     = 22'd1900000;
  localparam logic [21:0] NEG_BIG = 22'(-1900000);
  localparam logic [21:0] POS_MAX = 22'd1647099;
  localparam logic [21:0] NEG_MAX = 22'(-1647099);
  localparam logic [21:0] KVAL    = 22'd636751;

  cordic_launch_stage_if host ();

  cordic_launch_stage dut (
    .clk        (clk),
    .reset      (reset),
    .clk_en     (clk_en),
    .flush      (flush),
    .host       (host),
    .valid_out  (valid_out),
    .target_out (target_out),
    .angle      (angle),
    .x          (x),
    .y          (y),
    .sat_flag   (sat_flag),
    .occupancy  (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [21:0] t);
    host.in_valid  = v;
    host.in_target = t;
  endtask

  initial begin
    logic [21:0] exp_big, exp_neg;
    logic        exp_sat;
`ifdef CORDIC_LAUNCH_CLAMP_EN
    exp_big = POS_MAX; exp_neg = NEG_MAX; exp_sat = 1'b1;
`else
    exp_big = BIG;     exp_neg = NEG_BIG; exp_sat = 1'b0;
`endif
    reset = 1'b1; clk_en = 1'b0; flush = 1'b0;
    offer(1'b0, 22'd0);
    tick(); tick();
    chk("rst_occ",   32'(occupancy), 32'd0);
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_x",     32'(x), 32'd0);
    chk("rst_tgt",   32'(target_out), 32'd0);
    chk("rst_ready", 32'(host.in_ready), 32'd1);
    chk("rst_sat",   32'(sat_flag), 32'd0);
    reset = 1'b0;
    tick();

    // Streaming: each accept launches one edge later.
    clk_en = 1'b1;
    offer(1'b1, 22'h040000); tick();
    chk("str_nobypass", 32'(valid_out), 32'd0);
    chk("str_occ1",     32'(occupancy), 32'd1);
    offer(1'b1, 22'h080000); tick();
    chk("str_v0",   32'(valid_out), 32'd1);
    chk("str_t0",   32'(target_out), 32'h040000);
    chk("str_x",    32'(x), 32'(KVAL));
    chk("str_y",    32'(y), 32'd0);
    chk("str_ang",  32'(angle), 32'd0);
    offer(1'b1, 22'h0C0000); tick();
    chk("str_t1",   32'(target_out), 32'h080000);
    chk("str_occ",  32'(occupancy), 32'd1);
    offer(1'b0, 22'd0); tick();
    chk("str_v2",   32'(valid_out), 32'd1);
    chk("str_t2",   32'(target_out), 32'h0C0000);
    chk("str_occ0", 32'(occupancy), 32'd0);
    tick();
    chk("str_bub_v", 32'(valid_out), 32'd0);
    chk("str_bub_t", 32'(target_out), 32'h0C0000);

    // Stall and full
    clk_en = 1'b0;
    offer(1'b1, 22'h010000); tick();
    offer(1'b1, 22'h020000); tick();
    chk("full_occ",   32'(occupancy), 32'd2);
    chk("full_ready", 32'(host.in_ready), 32'd0);
    offer(1'b1, 22'h030000); tick();
    chk("full_hold_occ", 32'(occupancy), 32'd2);
    chk("stall_valid",   32'(valid_out), 32'd0);
    chk("stall_tgt",     32'(target_out), 32'h0C0000);
    clk_en = 1'b1; tick();
    chk("drain_t0",  32'(target_out), 32'h010000);
    chk("drain_occ", 32'(occupancy), 32'd1);
    tick();
    chk("drain_t1",  32'(target_out), 32'h020000);
    chk("drain_occ2", 32'(occupancy), 32'd1);
    offer(1'b0, 22'd0); tick();
    chk("drain_t2",  32'(target_out), 32'h030000);
    chk("drain_v2",  32'(valid_out), 32'd1);
    chk("drain_occ3", 32'(occupancy), 32'd0);

    // Bubble pattern 1,0,0
    clk_en = 1'b0;
    offer(1'b1, 22'h050000); tick();
    offer(1'b0, 22'd0); clk_en = 1'b1; tick();
    chk("bub_v1", 32'(valid_out), 32'd1);
    chk("bub_t1", 32'(target_out), 32'h050000);
    tick();
    chk("bub_v2", 32'(valid_out), 32'd0);
    tick();
    chk("bub_v3", 32'(valid_out), 32'd0);
    chk("bub_t3", 32'(target_out), 32'h050000);

    // Flush beats a simultaneous push
    clk_en = 1'b0;
    offer(1'b1, 22'h060000); tick();
    chk("fl_occ_pre", 32'(occupancy), 32'd1);
    flush = 1'b1; offer(1'b1, 22'h070000); tick();
    chk("fl_occ",   32'(occupancy), 32'd0);
    chk("fl_valid", 32'(valid_out), 32'd0);
    flush = 1'b0; offer(1'b0, 22'd0); clk_en = 1'b1; tick();
    chk("fl_drop_v", 32'(valid_out), 32'd0);
    chk("fl_tgt",    32'(target_out), 32'h050000);

    // Clamp (or pass-through when the feature is off)
    offer(1'b1, BIG); tick();
    offer(1'b1, NEG_BIG); tick();
    chk("clp_pos_t", 32'(target_out), 32'(exp_big));
    chk("clp_pos_s", 32'(sat_flag), 32'(exp_sat));
    offer(1'b1, 22'd1000); tick();
    chk("clp_neg_t", 32'(target_out), 32'(exp_neg));
    chk("clp_neg_s", 32'(sat_flag), 32'(exp_sat));
    offer(1'b0, 22'd0); tick();
    chk("clp_in_t", 32'(target_out), 32'd1000);
    chk("clp_in_s", 32'(sat_flag), 32'd0);

    // Asynchronous reset with two entries buffered
    clk_en = 1'b0;
    offer(1'b1, 22'h011111); tick();
    offer(1'b1, 22'h022222); tick();
    offer(1'b0, 22'd0);
    chk("mid_occ_pre", 32'(occupancy), 32'd2);
    chk("mid_v_pre",   32'(valid_out), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("mid_occ",   32'(occupancy), 32'd0);
    chk("mid_valid", 32'(valid_out), 32'd0);
    chk("mid_ready", 32'(host.in_ready), 32'd1);
    tick();
    reset = 1'b0; clk_en = 1'b1; tick();
    chk("mid_discard", 32'(valid_out), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
